// File: rtl/dtc_sched_pkg.sv
// Shared types and constants for the shared decision-tree classifier scheduler.
package dtc_sched_pkg;

    localparam int FEAT_W      = 12;
    localparam int CLS_W       = 3;
    localparam int NUM_CLASSES = 8;

    typedef logic [FEAT_W-1:0] feat_t;
    typedef logic [CLS_W-1:0]  cls_t;

endpackage

// File: rtl/dtc_rr_arbiter.sv
// Round-robin arbiter.
// The search starts at rr_ptr and wraps modulo NUM_REQ. The result is a one-hot
// grant plus its index. The pointer register is kept in the parent.
module dtc_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_grant
);

    // First requester at or after rr_ptr (wrapping) wins; nothing granted when disabled.
    always_comb begin : arb
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!any_grant && req[idx]) begin
                    any_grant = 1'b1;
                    grant_idx = IDW'(idx);
                end
            end
            if (any_grant) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_share_sched.sv
// Shares one combinational classifier among NUM_REQ requesters.
// Arbitration is round-robin. The datapath is a two-stage pipeline: an issue
// register that drives the classifier, then a result register tagged with the
// requester id. A saturating histogram counts each delivered class.
//
// Handshake rule for every interface: a transfer happens on a rising edge where
// valid and ready are both high. A valid that has been raised stays high, with
// stable data, until it is accepted. Ready may depend combinationally on valid
// (req_ready does).
module dtc_share_sched
    import dtc_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*FEAT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [FEAT_W-1:0]        cls_inp,
    input  logic [CLS_W-1:0]         cls_outp,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CLS_W-1:0]         res_class,
    output logic [IDW-1:0]           res_id,
    input  logic                     clr_stats,
    input  logic [2:0]               stat_sel,
    output logic [CNT_W-1:0]         stat_cnt
);

    logic               s1_valid;
    logic [IDW-1:0]     s1_id;
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               any_gnt;
    logic               s1_accept;
    logic               s2_accept;
    logic               arb_en;
    logic               res_xfer;
    feat_t              sel_feat;
    logic [CNT_W-1:0]   hist [NUM_CLASSES];

    // S2 can load whenever its current item leaves or it is empty; S1 chains on S2.
    assign s2_accept = !res_valid || res_ready;
    assign s1_accept = !s1_valid || s2_accept;
    assign res_xfer  = res_valid && res_ready;

    // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
    assign arb_en = en && s1_accept && rst_n;

    dtc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (arb_en),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any_grant (any_gnt)
    );

    assign req_ready = gnt;

    // Select the granted requester's feature vector.
    always_comb begin
        sel_feat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_feat = req_data[i*FEAT_W +: FEAT_W];
            end
        end
    end

    // Round-robin pointer: move just past the winner; hold when nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // Issue stage. cls_inp keeps its last value when S1 is empty or stalled, so
    // the classifier output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            cls_inp  <= '0;
        end else if (s1_accept) begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                s1_id   <= gnt_idx;
                cls_inp <= sel_feat;
            end
        end
    end

    // Result stage. It captures the classifier output and requester id, and
    // holds them after delivery until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_class <= '0;
            res_id    <= '0;
        end else if (s2_accept) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_class <= cls_outp;
                res_id    <= s1_id;
            end
        end
    end

    // Per-class histogram. Counters saturate, and a clear overrides a
    // coincident count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                hist[c] <= '0;
            end
        end else if (clr_stats) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                hist[c] <= '0;
            end
        end else if (res_xfer && (hist[res_class] != {CNT_W{1'b1}})) begin
            hist[res_class] <= hist[res_class] + CNT_W'(1);
        end
    end

    assign stat_cnt = hist[stat_sel];

endmodule

// File: tb/tb_dtc_share_sched.sv
// Directed bench for dtc_share_sched. It models a small decision tree as the
// external classifier, uses NUM_REQ=4 and CNT_W=4, and checks every expected
// value against a constant worked out by hand.
module tb_dtc_share_sched;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*12-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [11:0]          cls_inp;
    logic [2:0]           cls_outp;
    logic                 res_valid;
    logic                 res_ready;
    logic [2:0]           res_class;
    logic [1:0]           res_id;
    logic                 clr_stats;
    logic [2:0]           stat_sel;
    logic [CNT_W-1:0]     stat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] rv;
        logic       rr;
        logic [3:0] rdy;
        logic       vld;
        logic [1:0] id;
    } step_t;

    step_t      t4 [10];
    step_t      t5 [10];
    logic [2:0] exp_cls [4];

    dtc_share_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cls_inp   (cls_inp),
        .cls_outp  (cls_outp),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_id    (res_id),
        .clr_stats (clr_stats),
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
    );

    // External classifier model: bit 11 -> 7; else bit 7 -> (bit 5 ? 5 : 4); else low two bits.
    always_comb begin
        if (cls_inp[11])     cls_outp = 3'd7;
        else if (cls_inp[7]) cls_outp = cls_inp[5] ? 3'd5 : 3'd4;
        else                 cls_outp = {1'b0, cls_inp[1:0]};
    end

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [11:0] v);
        req_data[i*12 +: 12] = v;
    endtask

    task automatic check_bin(input string tag, input logic [2:0] sel, input logic [CNT_W-1:0] exp);
        stat_sel = sel;
        #1;
        chk(tag, 32'(stat_cnt), 32'(exp));
    endtask

    // Apply one table row, then check the grant and result outputs (no clock edge here).
    task automatic run_step(input string tag, input step_t s);
        en        = s.en;
        req_valid = s.rv;
        res_ready = s.rr;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(s.rdy));
        chk({tag, "_valid"}, 32'(res_valid), 32'(s.vld));
        if (s.vld) begin
            chk({tag, "_id"}, 32'(res_id), 32'(s.id));
            chk({tag, "_class"}, 32'(res_class), 32'(exp_cls[s.id]));
        end
    endtask

    initial begin
        exp_cls = '{3'd7, 3'd5, 3'd4, 3'd3};
        t4 = '{
            '{1'b1, 4'hf, 1'b1, 4'h4, 1'b0, 2'd0},
            '{1'b1, 4'hf, 1'b1, 4'h8, 1'b0, 2'd0},
            '{1'b1, 4'hf, 1'b0, 4'h0, 1'b1, 2'd2},
            '{1'b1, 4'hf, 1'b0, 4'h0, 1'b1, 2'd2},
            '{1'b1, 4'hf, 1'b0, 4'h0, 1'b1, 2'd2},
            '{1'b1, 4'hf, 1'b1, 4'h1, 1'b1, 2'd2},
            '{1'b1, 4'hf, 1'b1, 4'h2, 1'b1, 2'd3},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0}
        };
        t5 = '{
            '{1'b1, 4'hf, 1'b0, 4'h4, 1'b0, 2'd0},
            '{1'b1, 4'hf, 1'b0, 4'h8, 1'b0, 2'd0},
            '{1'b0, 4'hf, 1'b1, 4'h0, 1'b1, 2'd2},
            '{1'b0, 4'hf, 1'b1, 4'h0, 1'b1, 2'd3},
            '{1'b0, 4'hf, 1'b1, 4'h0, 1'b0, 2'd0},
            '{1'b0, 4'hf, 1'b1, 4'h0, 1'b0, 2'd0},
            '{1'b1, 4'hf, 1'b1, 4'h1, 1'b0, 2'd0},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0},
            '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0}
        };

        // Power-up reset, with requests pending so that req_ready gating is exercised.
        rst_n = 1'b0; en = 1'b1; req_valid = 4'hf; req_data = '0;
        res_ready = 1'b0; clr_stats = 1'b0; stat_sel = 3'd0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_cls_inp", 32'(cls_inp), 32'h0);
        chk("rst_class", 32'(res_class), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        chk("rst_cnt", 32'(stat_cnt), 32'h0);
        tick();
        tick();
        req_valid = 4'h0;
        rst_n = 1'b1;

        // Single request from requester 2
        tick();
        res_ready = 1'b1;
        set_data(2, 12'h0A5);
        req_valid = 4'b0100;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t2_cls_inp", 32'(cls_inp), 32'h0A5);
        chk("t2_valid_early", 32'(res_valid), 32'h0);
        chk("t2_ready_off", 32'(req_ready), 32'h0);
        tick();
        chk("t2_valid", 32'(res_valid), 32'h1);
        chk("t2_id", 32'(res_id), 32'h2);
        chk("t2_class", 32'(res_class), 32'h5);
        tick();
        chk("t2_valid_done", 32'(res_valid), 32'h0);
        check_bin("t2_bin5", 3'd5, 4'd1);

        // Reset pulse so that the fairness run starts at pointer 0
        rst_n = 1'b0;
        #1;
        check_bin("t2_bin5_rst", 3'd5, 4'd0);
        tick();
        rst_n = 1'b1;
        set_data(0, 12'h800);
        set_data(1, 12'h0A0);
        set_data(2, 12'h080);
        set_data(3, 12'h003);

        // Fairness: all four requesters continuously valid
        res_ready = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 10) ? 4'hf : 4'h0;
            #1;
            if (k < 10) chk("t3_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk("t3_valid", 32'(res_valid), 32'h1);
                chk("t3_id", 32'(res_id), 32'((k - 2) % 4));
                chk("t3_class", 32'(res_class), 32'(exp_cls[(k - 2) % 4]));
            end
            tick();
        end
        chk("t3_valid_done", 32'(res_valid), 32'h0);
        check_bin("t3_bin7", 3'd7, 4'd3);
        check_bin("t3_bin4", 3'd4, 4'd2);

        // Backpressure: res_ready low for three cycles while streaming
        for (int k = 0; k < 10; k++) begin
            run_step("t4", t4[k]);
            if (k >= 2 && k <= 4) chk("t4_cls_inp_hold", 32'(cls_inp), 32'h003);
            tick();
        end
        check_bin("t4_bin7", 3'd7, 4'd4);

        // Drain: en drops with S1 and S2 full, then resumes at the pointer
        for (int k = 0; k < 10; k++) begin
            run_step("t5", t5[k]);
            tick();
        end
        check_bin("t5_bin7", 3'd7, 4'd5);
        check_bin("t5_bin4", 3'd4, 4'd4);

        // Reset asserted mid-stall with a result pending
        en = 1'b1; res_ready = 1'b0; req_valid = 4'hf;
        tick();
        tick();
        chk("t1_valid_pre", 32'(res_valid), 32'h1);
        stat_sel = 3'd7;
        rst_n = 1'b0;
        #1;
        chk("t1_valid", 32'(res_valid), 32'h0);
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_bin7", 32'(stat_cnt), 32'h0);
        tick();
        req_valid = 4'h0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_no_result", 32'(res_valid), 32'h0);
        end

        // Stats: 20 results of class 5 saturate a 4-bit counter at 15
        for (int k = 0; k < 20; k++) begin
            req_valid = 4'b0010;
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        chk("t6_idle", 32'(res_valid), 32'h0);
        check_bin("t6_bin5_sat", 3'd5, 4'd15);
        check_bin("t6_bin7", 3'd7, 4'd0);

        // Clear coincident with a transfer: the clear wins and the result is not counted
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        clr_stats = 1'b1;
        #1;
        chk("t6_clr_valid", 32'(res_valid), 32'h1);
        tick();
        clr_stats = 1'b0;
        chk("t6_clr_done", 32'(res_valid), 32'h0);
        for (int b = 0; b < 8; b++) begin
            check_bin("t6_clr_bin", 3'(b), 4'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
